pwm_ramp_sequencer: RTL

//   Avalon-MM configured sequencer for one PWM_Controller instance. Holds shadow

---
 rtl/pwm_ramp_sequencer_if.sv | 11 +
 rtl/pwm_ramp_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_sequencer_if.sv
// Avalon-MM slave bus bundle for the PWM ramp sequencer register file.
interface pwm_ramp_sequencer_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (output address, write, writedata, read, input readdata);
  modport slave  (input address, write, writedata, read, output readdata);
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Shadowed period/duty sequencer for a PWM controller with boundary-aligned commits and duty ramp.
// Optional feature macro: PWM_SEQ_IRQ_EN (ramp-done interrupt, CTRL[2] mask, CTRL[9] pending).
module pwm_ramp_sequencer #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned DIV_WIDTH      = 16,
  parameter int unsigned DEFAULT_PERIOD = 999
) (
  input  logic                 clock,
  input  logic                 reset,
  pwm_ramp_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]     pwm_period,
  output logic [WIDTH-1:0]     pwm_compare,
  output logic                 busy
`ifdef PWM_SEQ_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STEP_W = 16;

  typedef enum logic [1:0] {S_OFF, S_RAMP, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic                  en_q, ramp_en_q;
  logic [WIDTH-1:0]      period_sh, target_sh;
  logic [STEP_W-1:0]     step_sh;
  logic [DIV_WIDTH-1:0]  div_sh, div_cnt, div_d;
  logic [WIDTH-1:0]      mirror, cur_d, ramp_val_c, step_w_c;
  logic [WIDTH:0]        up_sum_c, dn_dif_c;
  logic [DATA_W-1:0]     rd_c;
  logic                  wr_ctrl_c, wr_period_c, wr_target_c, wr_ramp_c;
  logic                  boundary_c, en_clear_c;
  logic                  unused_bits;

  assign wr_ctrl_c   = bus.write && (bus.address == 2'd0);
  assign wr_period_c = bus.write && (bus.address == 2'd1);
  assign wr_target_c = bus.write && (bus.address == 2'd2);
  assign wr_ramp_c   = bus.write && (bus.address == 2'd3);
  assign en_clear_c  = wr_ctrl_c && !bus.writedata[0];
  assign boundary_c  = (mirror == pwm_period);
  assign unused_bits = ^bus.writedata;

  // Next duty on a ramp tick: move by STEP with one spare bit, clamp at target.
  always_comb begin
    step_w_c = WIDTH'(step_sh);
    up_sum_c = {1'b0, pwm_compare} + {1'b0, step_w_c};
    dn_dif_c = {1'b0, pwm_compare} - {1'b0, step_w_c};
    ramp_val_c = target_sh;
    if (step_w_c != '0) begin
      if (target_sh > pwm_compare) begin
        if (up_sum_c < {1'b0, target_sh}) ramp_val_c = up_sum_c[WIDTH-1:0];
      end else begin
        if (!dn_dif_c[WIDTH] && (dn_dif_c[WIDTH-1:0] > target_sh)) ramp_val_c = dn_dif_c[WIDTH-1:0];
      end
    end
  end

  // State is resolved from the next duty so busy drops on the same edge the duty lands.
  always_comb begin
    state_d = state_q;
    cur_d   = pwm_compare;
    div_d   = div_cnt;
    unique case (state_q)
      S_OFF: begin
        cur_d = '0;
        div_d = '0;
      end
      S_RAMP: begin
        if (boundary_c) begin
          if (div_cnt >= div_sh) begin
            div_d = '0;
            cur_d = ramp_val_c;
          end else begin
            div_d = div_cnt + DIV_WIDTH'(1);
          end
        end
      end
      S_HOLD: begin
        div_d = '0;
        if (boundary_c && !ramp_en_q) cur_d = target_sh;
      end
      default: begin
        cur_d = '0;
        div_d = '0;
      end
    endcase
    if (!en_q || en_clear_c) begin
      state_d = S_OFF;
      cur_d   = '0;
      div_d   = '0;
    end else if (ramp_en_q && (cur_d != target_sh)) begin
      state_d = S_RAMP;
    end else begin
      state_d = S_HOLD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_OFF;
    else       state_q <= state_d;
  end

`ifdef PWM_SEQ_IRQ_EN
  logic irq_mask_q, irq_pend_q, irq_mask_d, irq_pend_d;

  // Completion set wins over a same-cycle software clear.
  always_comb begin
    irq_mask_d = wr_ctrl_c ? bus.writedata[2] : irq_mask_q;
    irq_pend_d = irq_pend_q;
    if (wr_ctrl_c && bus.writedata[9]) irq_pend_d = 1'b0;
    if ((state_q == S_RAMP) && (state_d == S_HOLD)) irq_pend_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_mask_q <= 1'b0;
      irq_pend_q <= 1'b0;
      irq        <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_pend_q <= irq_pend_d;
      irq        <= irq_pend_d & irq_mask_d;
    end
  end
`endif

  always_comb begin
    rd_c = '0;
    unique case (bus.address)
      2'd0: begin
        rd_c[0] = en_q;
        rd_c[1] = ramp_en_q;
        rd_c[8] = busy;
`ifdef PWM_SEQ_IRQ_EN
        rd_c[2] = irq_mask_q;
        rd_c[9] = irq_pend_q;
`endif
      end
      2'd1: rd_c[WIDTH-1:0] = period_sh;
      2'd2: begin
        rd_c[WIDTH-1:0] = target_sh;
        rd_c[31:16]     = 16'(pwm_compare);
      end
      2'd3: rd_c = {16'(div_sh), step_sh};
      default: rd_c = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      en_q         <= 1'b0;
      ramp_en_q    <= 1'b0;
      period_sh    <= WIDTH'(DEFAULT_PERIOD);
      target_sh    <= '0;
      step_sh      <= '0;
      div_sh       <= '0;
      div_cnt      <= '0;
      mirror       <= '0;
      pwm_period   <= WIDTH'(DEFAULT_PERIOD);
      pwm_compare  <= '0;
      busy         <= 1'b0;
      bus.readdata <= '0;
    end else begin
      if (wr_ctrl_c) begin
        en_q      <= bus.writedata[0];
        ramp_en_q <= bus.writedata[1];
      end
      if (wr_period_c) period_sh <= WIDTH'(bus.writedata);
      if (wr_target_c) target_sh <= WIDTH'(bus.writedata);
      if (wr_ramp_c) begin
        step_sh <= bus.writedata[15:0];
        div_sh  <= DIV_WIDTH'(bus.writedata[31:16]);
      end
      // Mirror of the controller's counter; period commits use the pre-write shadow.
      mirror <= boundary_c ? '0 : mirror + WIDTH'(1);
      if (boundary_c) pwm_period <= period_sh;
      pwm_compare <= cur_d;
      div_cnt     <= div_d;
      busy        <= (state_d == S_RAMP);
      if (bus.read) bus.readdata <= rd_c;
    end
  end

endmodule
